// File: rtl/vga_pkg.sv
// vga_pkg: shared pixel/colour widths, background colour and the rectangle config record
package vga_pkg;
    localparam int DEF_XW = 10;
    localparam int DEF_YW = 10;
    localparam int DEF_CW = 12;
    localparam logic [DEF_CW-1:0] DEF_BG_COLOR = 12'h000;

    typedef struct packed {
        logic              en;
        logic [DEF_XW-1:0] x0;
        logic [DEF_YW-1:0] y0;
        logic [DEF_XW-1:0] w;
        logic [DEF_YW-1:0] h;
        logic [DEF_CW-1:0] color;
    } rect_cfg_t;
endpackage

// File: rtl/rect_hit.sv
// rect_hit: registered hit test of one pixel against one rectangle slot
module rect_hit
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  rect_cfg_t         cfg_i,
    input  logic [DEF_XW-1:0] x_i,
    input  logic [DEF_YW-1:0] y_i,
    output logic              in_o
);
    // One extra bit so x0+w / y0+h never wrap back onto the left/top of the screen.
    logic [DEF_XW:0] right;
    logic [DEF_YW:0] bottom;
    logic            in_d, in_q;

    assign right  = {1'b0, cfg_i.x0} + {1'b0, cfg_i.w};
    assign bottom = {1'b0, cfg_i.y0} + {1'b0, cfg_i.h};
    assign in_d   = cfg_i.en && x_i >= cfg_i.x0 && {1'b0, x_i} < right
                             && y_i >= cfg_i.y0 && {1'b0, y_i} < bottom;
    assign in_o   = in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_q <= 1'b0;
        else        in_q <= in_d;
    end
endmodule

// File: rtl/rect_compositor.sv
// rect_compositor: draws N_RECT prioritised solid rectangles over a background, 2-cycle pipeline
module rect_compositor
    import vga_pkg::*;
#(
    parameter int            N_RECT   = 4,
    parameter int            XW       = DEF_XW,
    parameter int            YW       = DEF_YW,
    parameter int            CW       = DEF_CW,
    parameter logic [CW-1:0] BG_COLOR = DEF_BG_COLOR,
    parameter int            IDXW     = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XW-1:0]   x,
    input  logic [YW-1:0]   y,
    input  logic            display,
    input  logic            frame_start,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic            cfg_en,
    input  logic [XW-1:0]   cfg_x0,
    input  logic [YW-1:0]   cfg_y0,
    input  logic [XW-1:0]   cfg_w,
    input  logic [YW-1:0]   cfg_h,
    input  logic [CW-1:0]   cfg_color,
    output logic [CW-1:0]   rgb,
    output logic            display_o,
    output logic            hit,
    output logic [IDXW-1:0] hit_idx
);
    rect_cfg_t         shadow_q [N_RECT];
    rect_cfg_t         active_q [N_RECT];
    rect_cfg_t         wr_cfg;
    logic [CW-1:0]     color_q [N_RECT];
    logic [N_RECT-1:0] in_s1;
    logic              ready_q, accept, disp1_q, disp2_q, found, hit_d, hit_q;
    logic [IDXW-1:0]   win, idx_d, idx_q;
    logic [CW-1:0]     rgb_d, rgb_q;

    // The commit cycle refuses writes so the shadow copied into active is stable.
    assign cfg_ready = ready_q && !frame_start;
    assign accept    = cfg_valid && cfg_ready;
    assign wr_cfg    = '{en: cfg_en, x0: cfg_x0, y0: cfg_y0, w: cfg_w, h: cfg_h, color: cfg_color};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            for (int i = 0; i < N_RECT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            for (int i = 0; i < N_RECT; i++) begin
                if (accept && int'(cfg_idx) == i) shadow_q[i] <= wr_cfg;
                if (frame_start) active_q[i] <= shadow_q[i];
            end
        end
    end

    for (genvar i = 0; i < N_RECT; i++) begin : g_slot
        rect_hit u_hit (
            .clk   (clk),
            .rst_n (rst_n),
            .cfg_i (active_q[i]),
            .x_i   (x),
            .y_i   (y),
            .in_o  (in_s1[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp1_q <= 1'b0;
            for (int i = 0; i < N_RECT; i++) color_q[i] <= '0;
        end else begin
            disp1_q <= display;
            for (int i = 0; i < N_RECT; i++) color_q[i] <= active_q[i].color;
        end
    end

    // Scan from the top so the lowest-indexed hitting slot is left in win.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (in_s1[i]) begin
                found = 1'b1;
                win   = IDXW'(i);
            end
        end
        hit_d = disp1_q && found;
        idx_d = hit_d ? win : '0;
        rgb_d = !disp1_q ? '0 : found ? color_q[win] : BG_COLOR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp2_q <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            rgb_q   <= '0;
        end else begin
            disp2_q <= disp1_q;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            rgb_q   <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign display_o = disp2_q;
    assign hit       = hit_q;
    assign hit_idx   = idx_q;
endmodule

// File: tb/tb_rect_compositor.sv
// tb_rect_compositor: table + scoreboard checks of the rectangle compositor against a bench model
module tb_rect_compositor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        display = 1'b0, frame_start = 1'b0;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [1:0]  cfg_idx = '0;
    logic        cfg_en = 1'b0;
    logic [9:0]  cfg_x0 = '0, cfg_y0 = '0, cfg_w = '0, cfg_h = '0;
    logic [11:0] cfg_color = '0;
    logic [11:0] rgb;
    logic        display_o, hit;
    logic [1:0]  hit_idx;

    rect_compositor dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .display(display), .frame_start(frame_start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_color(cfg_color),
        .rgb(rgb), .display_o(display_o), .hit(hit), .hit_idx(hit_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        d;
        logic        h;
        logic [1:0]  idx;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        int          en, x0, y0, w, h;
        logic [11:0] c;
    } mrect_t;

    typedef struct {
        int   px, py;
        logic d;
        exp_t e;
    } vec_t;

    mrect_t sh_m[4], ac_m[4];
    logic   rdy_m;
    exp_t   sb[$];
    int     total = 0, bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input int px, input int py, input logic d);
        exp_t e;
        e = '0;
        if (d) begin
            e.d   = 1'b1;
            e.rgb = 12'h000;
            for (int i = 3; i >= 0; i--)
                if (ac_m[i].en != 0 && px >= ac_m[i].x0 && px < ac_m[i].x0 + ac_m[i].w &&
                    py >= ac_m[i].y0 && py < ac_m[i].y0 + ac_m[i].h) begin
                    e.h   = 1'b1;
                    e.idx = 2'(i);
                    e.rgb = ac_m[i].c;
                end
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            sh_m[i] = '{0, 0, 0, 0, 0, 12'h000};
            ac_m[i] = '{0, 0, 0, 0, 0, 12'h000};
        end
        rdy_m = 1'b0;
        sb.delete();
    endtask

    // One clock: drive at negedge, check cfg_ready, update model at posedge, check output of previous pixel.
    task automatic cyc(input int px, input int py, input logic d, input logic fs, input exp_t e);
        exp_t q;
        x = 10'(px);
        y = 10'(py);
        display = d;
        frame_start = fs;
        #1;
        chk("cfg_ready", {15'd0, cfg_ready}, {15'd0, rdy_m && !fs});
        sb.push_back(e);
        @(posedge clk);
        if (cfg_valid && rdy_m && !fs)
            sh_m[cfg_idx] = '{int'(cfg_en), int'(cfg_x0), int'(cfg_y0), int'(cfg_w), int'(cfg_h), cfg_color};
        if (fs) ac_m = sh_m;
        rdy_m = 1'b1;
        @(negedge clk);
        if (sb.size() == 2) begin
            q = sb.pop_front();
            chk("pixel", {display_o, hit, hit_idx, rgb}, q);
        end
    endtask

    task automatic pix(input int px, input int py);
        cyc(px, py, 1'b1, 1'b0, model(px, py, 1'b1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic commit();
        cyc(0, 0, 1'b0, 1'b1, '0);
    endtask

    task automatic wr(input int idx, input logic en, input int x0, input int y0,
                      input int w, input int h, input logic [11:0] c);
        cfg_idx = 2'(idx); cfg_en = en; cfg_x0 = 10'(x0); cfg_y0 = 10'(y0);
        cfg_w = 10'(w); cfg_h = 10'(h); cfg_color = c;
        cfg_valid = 1'b1;
        idle(1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out", {display_o, hit, hit_idx, rgb}, 16'h0000);
        chk("reset_ready", {15'd0, cfg_ready}, 16'h0000);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{10, 20, 1'b1, '{1'b1, 1'b1, 2'd0, 12'hF00}};
        tbl[1] = '{14, 22, 1'b1, '{1'b1, 1'b1, 2'd0, 12'hF00}};
        tbl[2] = '{15, 22, 1'b1, '{1'b1, 1'b0, 2'd0, 12'h000}};
        tbl[3] = '{14, 23, 1'b1, '{1'b1, 1'b0, 2'd0, 12'h000}};
        tbl[4] = '{9,  20, 1'b1, '{1'b1, 1'b0, 2'd0, 12'h000}};
        tbl[5] = '{10, 19, 1'b1, '{1'b1, 1'b0, 2'd0, 12'h000}};
        tbl[6] = '{12, 21, 1'b0, '{1'b0, 1'b0, 2'd0, 12'h000}};
        tbl[7] = '{12, 21, 1'b1, '{1'b1, 1'b1, 2'd0, 12'hF00}};

        @(negedge clk);
        do_reset();

        // Empty frame: background everywhere, zero outside display
        commit();
        for (int i = 0; i < 8; i++) pix(i * 3, i);
        cyc(5, 5, 1'b0, 1'b0, '0);
        idle(1);

        // Single rectangle, table-driven edges
        wr(0, 1'b1, 10, 20, 5, 3, 12'hF00);
        commit();
        foreach (tbl[i]) cyc(tbl[i].px, tbl[i].py, tbl[i].d, 1'b0, tbl[i].e);
        idle(1);

        // Overlap priority, then disable the winner
        wr(2, 1'b1, 12, 21, 10, 10, 12'h0F0);
        commit();
        pix(12, 21); pix(16, 21); pix(21, 30);
        wr(0, 1'b0, 10, 20, 5, 3, 12'hF00);
        pix(12, 21);
        commit();
        pix(12, 21);
        idle(1);

        // Mid-frame write stays hidden until commit; commit with display high
        wr(1, 1'b1, 100, 100, 4, 4, 12'h00F);
        pix(101, 101);
        cyc(101, 101, 1'b1, 1'b1, model(101, 101, 1'b1));
        pix(101, 101); pix(103, 103); pix(104, 103);
        idle(1);

        // Request held across the commit cycle
        cfg_idx = 2'd3; cfg_en = 1'b1; cfg_x0 = 10'd200; cfg_y0 = 10'd200;
        cfg_w = 10'd2; cfg_h = 10'd2; cfg_color = 12'hFFF;
        cfg_valid = 1'b1;
        commit();
        idle(1);
        cfg_valid = 1'b0;
        pix(200, 200);
        commit();
        pix(200, 200); pix(201, 201); pix(202, 200);
        idle(1);

        // Right edge beyond the screen must not wrap to x=0
        wr(3, 1'b1, 1000, 0, 100, 10, 12'h0FF);
        commit();
        for (int px = 0; px <= 75; px += 5) pix(px, 5);
        pix(999, 5); pix(1000, 5); pix(1023, 5);
        idle(1);

        // Zero width never hits
        wr(1, 1'b1, 50, 50, 0, 5, 12'hABC);
        commit();
        pix(50, 50); pix(50, 52);
        idle(1);

        // Async reset while a hit is on the outputs
        pix(12, 21); pix(12, 21);
        do_reset();
        commit();
        pix(12, 21); pix(1000, 5); pix(200, 200);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rect_compositor.md
Name: rect_compositor

Overview:
- Draws up to N_RECT solid rectangles over a background colour, on the pixel stream produced by the VGA timing generator.
- Registered, pipelined successor to the single-rectangle combinational drawer.
- Each rectangle has its own geometry, colour and enable, written through a valid/ready config port.
- Config writes land in a shadow bank that becomes active only at the frame boundary, so the picture never tears mid-frame.

Parameters:
N_RECT, 4, number of rectangle slots; lower index has higher priority
XW, 10, pixel x coordinate and width bits
YW, 10, pixel y coordinate and height bits
CW, 12, colour bits (4:4:4 RGB)
BG_COLOR, 12'h000, colour output for visible pixels covered by no enabled rectangle
IDXW, $clog2(N_RECT) (min 1), slot index width (derived)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
x  in  XW  current pixel column
y  in  YW  current pixel row
display  in  1  high in the visible area
frame_start  in  1  one-cycle pulse at the start of vertical blanking; commits the shadow bank
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready
cfg_idx  in  IDXW  slot being written
cfg_en  in  1  slot enable
cfg_x0  in  XW  left edge
cfg_y0  in  YW  top edge
cfg_w  in  XW  width
cfg_h  in  YW  height
cfg_color  in  CW  fill colour
rgb  out  CW  pixel colour, aligned with display_o
display_o  out  1  display delayed by 2 cycles
hit  out  1  pixel lies inside an enabled rectangle
hit_idx  out  IDXW  winning slot index; 0 when hit=0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All shadow and active slots cleared: en=0, geometry=0, color=0.
  - Outputs: rgb=0, display_o=0, hit=0, hit_idx=0, cfg_ready=0.
  - cfg_ready goes to 1 on the first clk after reset is released.
  - If reset is asserted mid-frame, the next visible pixels show BG_COLOR.
- Config handshake:
  - cfg_ready = 1 except in the cycle in which frame_start=1.
  - On acceptance, shadow[cfg_idx] <= {cfg_en, cfg_x0, cfg_y0, cfg_w, cfg_h, cfg_color}.
  - A write with cfg_idx >= N_RECT is accepted and dropped.
  - Writing the same slot again before a commit overwrites it; last write wins.
- Commit: when frame_start=1, every active[i] <= shadow[i] in that cycle. Shadow contents are kept.
- Pipeline, latency 2 from x/y/display to rgb/display_o/hit:
  - Stage 1, per slot i, registered: in_i = active.en && x >= x0 && x < x0+w && y >= y0 && y < y0+h. Also registers display and each slot colour.
  - Stage 2: lowest i with in_i=1 wins.
  - If display_d1=0: rgb=0, hit=0, hit_idx=0.
  - Else if a slot wins: rgb=color_i, hit=1, hit_idx=i.
  - Else: rgb=BG_COLOR, hit=0, hit_idx=0.
- Arithmetic:
  - Right and bottom edges are computed as XW+1 and YW+1 bit sums, so they never wrap. Example: x0=1000, w=100 gives right edge 1100 and clips at the screen edge.
  - w=0 or h=0 draws nothing.
  - The right/bottom edge is exclusive; the left/top edge is inclusive.
- Simultaneous events:
  - cfg_valid coinciding with frame_start is not accepted; the master holds the request and it is accepted next cycle, into the shadow bank for the following frame.
  - frame_start while display=1 is legal: the commit takes effect for pixels entering stage 1 on the next cycle.

Decomposition:
- Shared package vga_pkg: the rect_cfg_t struct {en, x0, y0, w, h, color}, default widths XW/YW/CW, and the BG_COLOR default.
- One sub-module, rect_hit: a single-slot registered hit test (stage 1), instantiated N_RECT times with generate.
- Priority encoder, shadow/active banks and handshake live in the top level.

Test Plan:
- Reset, then frame_start with no writes; sweep visible pixels -> rgb=BG_COLOR, hit=0 throughout; rgb=0 when display=0.
- Write slot0 {en=1, x0=10, y0=20, w=5, h=3, color=12'hF00}, then frame_start -> pixel (10,20) gives rgb=F00, hit=1 two cycles later. (14,22) hits; (15,22) and (14,23) do not.
- Slot0 and slot2 overlap, colours F00/0F0 -> overlap shows F00 with hit_idx=0. Disable slot0 and commit -> overlap shows 0F0 with hit_idx=2.
- Write slot1 mid-frame without frame_start -> display unchanged until the next frame_start, then the new rectangle appears.
- cfg_valid held in the frame_start cycle -> cfg_ready=0 that cycle; accepted next cycle; not visible until the following commit.
- Edge cases:
  - x0=1000, w=100 -> no wrap hit at x=0..75.
  - w=0 -> never hits.
  - rst_n pulsed low mid-frame -> outputs go to 0 immediately and all slots are disabled.
